des_decrypt_key_sched: RTL and testbench

DES_DECRYPT_KEY_SCHED -- requirements
Module: des_decrypt_key_sched

---
 rtl/des_decrypt_key_sched.sv | 144 ++++++++++++++
 tb/tb_des_decrypt_key_sched.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/des_decrypt_key_sched.sv
// DES decryption key schedule: produces subkeys K16..K1 one per accepted
// handshake. C/D are loaded once from PC-1 of the key and rotated right
// between rounds. Subkeys are PC-2 of the registered C/D.
module des_decrypt_key_sched (
  input  logic        clk,
  input  logic        n_rst,
  input  logic [63:0] key_in,
  input  logic        key_load,
  input  logic        subkey_ack,
  output logic [47:0] subkey_out,
  output logic        subkey_valid,
  output logic [3:0]  round_idx,
  output logic        sched_done
);

  typedef enum logic [1:0] {
    StIdle,
    StActive,
    StDone
  } state_e;

  // Permuted choice 1, FIPS bit numbering (bit 1 = MSB of key_in).
  localparam int unsigned Pc1Tbl [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  // Permuted choice 2 over {C,D}, bit 1 = MSB of C.
  localparam int unsigned Pc2Tbl [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  function automatic logic [55:0] pc1(input logic [63:0] key);
    logic [55:0] res;
    res = '0;
    for (int i = 0; i < 56; i++) begin
      res[6'(55 - i)] = key[6'(64 - Pc1Tbl[i])];
    end
    return res;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] res;
    res = '0;
    for (int i = 0; i < 48; i++) begin
      res[6'(47 - i)] = cd[6'(56 - Pc2Tbl[i])];
    end
    return res;
  endfunction

  state_e      state_q, state_d;
  logic [27:0] c_q, c_d;
  logic [27:0] d_q, d_d;
  logic [3:0]  round_q, round_d;

  logic [3:0]  round_nxt;
  logic        rot_two;
  logic [55:0] key_pc1;

  assign round_nxt = round_q + 4'd1;
  // Decryption walks the encryption shifts backwards; single shifts land on
  // new rounds 1, 8 and 15, everything else rotates by two.
  assign rot_two   = !((round_nxt == 4'd1) || (round_nxt == 4'd8) || (round_nxt == 4'd15));
  assign key_pc1   = pc1(key_in);

  // Next-state: load has priority over ack in every state.
  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    d_d     = d_q;
    round_d = round_q;
    if (key_load) begin
      state_d = StActive;
      c_d     = key_pc1[55:28];
      d_d     = key_pc1[27:0];
      round_d = 4'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d = StIdle;
        end
        StActive: begin
          if (subkey_ack) begin
            if (round_q == 4'd15) begin
              state_d = StDone;
            end else begin
              round_d = round_nxt;
              if (rot_two) begin
                c_d = {c_q[1:0], c_q[27:2]};
                d_d = {d_q[1:0], d_q[27:2]};
              end else begin
                c_d = {c_q[0], c_q[27:1]};
                d_d = {d_q[0], d_q[27:1]};
              end
            end
          end
        end
        StDone: begin
          state_d = StIdle;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  // State and key-half registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= StIdle;
      c_q     <= '0;
      d_q     <= '0;
      round_q <= '0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      d_q     <= d_d;
      round_q <= round_d;
    end
  end

  // Outputs derive directly from registered state.
  always_comb begin
    subkey_out   = pc2({c_q, d_q});
    subkey_valid = (state_q == StActive);
    sched_done   = (state_q == StDone);
    round_idx    = round_q;
  end

endmodule

// File: tb/tb_des_decrypt_key_sched.sv
// Directed bench for des_decrypt_key_sched plus a forward-direction
// reference schedule for random keys.
module tb_des_decrypt_key_sched;

  logic        clk;
  logic        n_rst;
  logic [63:0] key_in;
  logic        key_load;
  logic        subkey_ack;
  logic [47:0] subkey_out;
  logic        subkey_valid;
  logic [3:0]  round_idx;
  logic        sched_done;

  int total;
  int bad;

  localparam logic [63:0] KeyA = 64'h133457799BBCDFF1;
  // C all ones, D all zeros after PC-1: every subkey is FFFFFF000000.
  localparam logic [63:0] KeyB = 64'hE0E0E0E0F0F0F0F0;
  localparam logic [47:0] KeyBK16 = 48'hFFFFFF000000;

  // K1..K16 of KeyA (classic worked example).
  localparam logic [47:0] KRef [16] = '{
    48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
    48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
    48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
    48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
  };

  localparam int unsigned MPc1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int unsigned MPc2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  localparam int unsigned EncShift [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  logic [47:0] exp_ks [1:16];

  des_decrypt_key_sched dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .key_in       (key_in),
    .key_load     (key_load),
    .subkey_ack   (subkey_ack),
    .subkey_out   (subkey_out),
    .subkey_valid (subkey_valid),
    .round_idx    (round_idx),
    .sched_done   (sched_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [55:0] m_pc1(input logic [63:0] k);
    logic [55:0] r;
    r = '0;
    for (int i = 0; i < 56; i++) r[55-i] = k[64-MPc1[i]];
    return r;
  endfunction

  function automatic logic [47:0] m_pc2(input logic [55:0] cd);
    logic [47:0] r;
    r = '0;
    for (int i = 0; i < 48; i++) r[47-i] = cd[56-MPc2[i]];
    return r;
  endfunction

  // Forward encryption schedule with left shifts; fills exp_ks[1..16].
  task automatic build_ref(input logic [63:0] k);
    logic [55:0] cd;
    logic [27:0] c;
    logic [27:0] d;
    cd = m_pc1(k);
    c  = cd[55:28];
    d  = cd[27:0];
    for (int rnd = 1; rnd <= 16; rnd++) begin
      for (int s = 0; s < int'(EncShift[rnd-1]); s++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      exp_ks[rnd] = m_pc2({c, d});
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [63:0] k);
    key_in   = k;
    key_load = 1'b1;
    step();
    key_load = 1'b0;
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    step();
    step();
    total++;
    if ({subkey_valid, sched_done, round_idx, subkey_out} !== 54'd0) begin
      bad++;
      $display("FAIL reset_state: got v=%b d=%b idx=%0d sk=%h want all zero",
               subkey_valid, sched_done, round_idx, subkey_out);
    end
    n_rst = 1'b1;
    step();
    step();
    step();
    total++;
    if ({subkey_valid, sched_done, round_idx, subkey_out} !== 54'd0) begin
      bad++;
      $display("FAIL post_reset_idle: got v=%b d=%b idx=%0d sk=%h want all zero",
               subkey_valid, sched_done, round_idx, subkey_out);
    end
  endtask

  task automatic test_load_hold();
    subkey_ack = 1'b0;
    do_load(KeyA);
    for (int c = 0; c < 6; c++) begin
      total++;
      if ({subkey_valid, sched_done, round_idx, subkey_out} !== {1'b1, 1'b0, 4'd0, KRef[15]})
      begin
        bad++;
        $display("FAIL load_hold cyc%0d: got v=%b d=%b idx=%0d sk=%h want v=1 d=0 idx=0 sk=%h",
                 c, subkey_valid, sched_done, round_idx, subkey_out, KRef[15]);
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    subkey_ack = 1'b0;
    do_load(KeyA);
    subkey_ack = 1'b1;
    for (int r = 0; r < 16; r++) begin
      total++;
      if ({subkey_valid, sched_done, round_idx, subkey_out} !==
          {1'b1, 1'b0, 4'(r), KRef[15-r]}) begin
        bad++;
        $display("FAIL b2b round%0d: got v=%b d=%b idx=%0d sk=%h want v=1 d=0 idx=%0d sk=%h",
                 r, subkey_valid, sched_done, round_idx, subkey_out, r, KRef[15-r]);
      end
      step();
    end
    total++;
    if ({subkey_valid, sched_done} !== 2'b01) begin
      bad++;
      $display("FAIL b2b_done_pulse: got v=%b d=%b want v=0 d=1", subkey_valid, sched_done);
    end
    for (int c = 0; c < 3; c++) begin
      step();
      total++;
      if ({subkey_valid, sched_done} !== 2'b00) begin
        bad++;
        $display("FAIL b2b_after_done%0d: got v=%b d=%b want v=0 d=0",
                 c, subkey_valid, sched_done);
      end
    end
    subkey_ack = 1'b0;
  endtask

  task automatic test_abort();
    subkey_ack = 1'b0;
    do_load(KeyA);
    subkey_ack = 1'b1;
    repeat (7) step();
    total++;
    if ({round_idx, subkey_out} !== {4'd7, KRef[8]}) begin
      bad++;
      $display("FAIL abort_pre: got idx=%0d sk=%h want idx=7 sk=%h", round_idx, subkey_out, KRef[8]);
    end
    key_in   = KeyB;
    key_load = 1'b1;
    step();
    key_load = 1'b0;
    total++;
    if ({subkey_valid, sched_done, round_idx, subkey_out} !== {1'b1, 1'b0, 4'd0, KeyBK16}) begin
      bad++;
      $display("FAIL abort_reload: got v=%b d=%b idx=%0d sk=%h want v=1 d=0 idx=0 sk=%h",
               subkey_valid, sched_done, round_idx, subkey_out, KeyBK16);
    end
    // key_in changes after the load edge must not leak in.
    key_in = KeyA;
    step();
    total++;
    if ({subkey_valid, round_idx, subkey_out} !== {1'b1, 4'd1, KeyBK16}) begin
      bad++;
      $display("FAIL key_sampled_once: got v=%b idx=%0d sk=%h want v=1 idx=1 sk=%h",
               subkey_valid, round_idx, subkey_out, KeyBK16);
    end
    repeat (14) step();
    total++;
    if ({subkey_valid, round_idx} !== {1'b1, 4'd15}) begin
      bad++;
      $display("FAIL abort_reach15: got v=%b idx=%0d want v=1 idx=15", subkey_valid, round_idx);
    end
    // Load and ack together at the last round: load wins, no done pulse.
    key_in   = KeyA;
    key_load = 1'b1;
    step();
    key_load = 1'b0;
    total++;
    if ({subkey_valid, sched_done, round_idx, subkey_out} !== {1'b1, 1'b0, 4'd0, KRef[15]}) begin
      bad++;
      $display("FAIL load_priority_15: got v=%b d=%b idx=%0d sk=%h want v=1 d=0 idx=0 sk=%h",
               subkey_valid, sched_done, round_idx, subkey_out, KRef[15]);
    end
    subkey_ack = 1'b0;
  endtask

  task automatic test_reset_mid();
    subkey_ack = 1'b0;
    do_load(KeyA);
    subkey_ack = 1'b1;
    repeat (9) step();
    subkey_ack = 1'b0;
    total++;
    if ({round_idx, subkey_out} !== {4'd9, KRef[6]}) begin
      bad++;
      $display("FAIL rst_mid_pre: got idx=%0d sk=%h want idx=9 sk=%h", round_idx, subkey_out, KRef[6]);
    end
    #2;
    n_rst = 1'b0;
    #1;
    total++;
    if ({subkey_valid, sched_done, round_idx, subkey_out} !== 54'd0) begin
      bad++;
      $display("FAIL rst_async: got v=%b d=%b idx=%0d sk=%h want all zero",
               subkey_valid, sched_done, round_idx, subkey_out);
    end
    step();
    n_rst      = 1'b1;
    subkey_ack = 1'b1;
    step();
    step();
    total++;
    if ({subkey_valid, sched_done, round_idx, subkey_out} !== 54'd0) begin
      bad++;
      $display("FAIL rst_ack_ignored: got v=%b d=%b idx=%0d sk=%h want all zero",
               subkey_valid, sched_done, round_idx, subkey_out);
    end
    subkey_ack = 1'b0;
  endtask

  task automatic test_ack_idle_done();
    subkey_ack = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      total++;
      if ({subkey_valid, sched_done, round_idx} !== 6'd0) begin
        bad++;
        $display("FAIL ack_idle%0d: got v=%b d=%b idx=%0d want 0 0 0",
                 c, subkey_valid, sched_done, round_idx);
      end
    end
    subkey_ack = 1'b0;
    do_load(KeyA);
    subkey_ack = 1'b1;
    repeat (16) step();
    total++;
    if (sched_done !== 1'b1) begin
      bad++;
      $display("FAIL ack_done_pulse: got d=%b want 1", sched_done);
    end
    for (int c = 0; c < 2; c++) begin
      step();
      total++;
      if ({subkey_valid, sched_done} !== 2'b00) begin
        bad++;
        $display("FAIL ack_after_done%0d: got v=%b d=%b want 0 0", c, subkey_valid, sched_done);
      end
    end
    subkey_ack = 1'b0;
  endtask

  task automatic test_random();
    logic [63:0] k;
    int unsigned gap;
    for (int n = 0; n < 20; n++) begin
      k = {$urandom, $urandom};
      build_ref(k);
      subkey_ack = 1'b0;
      do_load(k);
      for (int r = 0; r < 16; r++) begin
        gap = $urandom_range(0, 2);
        repeat (gap) step();
        total++;
        if ({subkey_valid, round_idx, subkey_out} !== {1'b1, 4'(r), exp_ks[16-r]}) begin
          bad++;
          $display("FAIL rand key%0d round%0d: got v=%b idx=%0d sk=%h want v=1 idx=%0d sk=%h",
                   n, r, subkey_valid, round_idx, subkey_out, r, exp_ks[16-r]);
        end
        subkey_ack = 1'b1;
        step();
        subkey_ack = 1'b0;
      end
      total++;
      if ({subkey_valid, sched_done} !== 2'b01) begin
        bad++;
        $display("FAIL rand_done key%0d: got v=%b d=%b want v=0 d=1", n, subkey_valid, sched_done);
      end
      step();
    end
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    n_rst      = 1'b0;
    key_in     = '0;
    key_load   = 1'b0;
    subkey_ack = 1'b0;
    test_reset();
    test_load_hold();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    test_ack_idle_done();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
